// File: rtl/issue_queue_pkg.sv
// Shared types for the fetch-to-decode issue queue: entry layout, FSM states
// and the decoder optype encoding.
package issue_queue_pkg;

    localparam int IQ_DEPTH = 8;

    typedef enum logic [2:0] {
        OP_ALU   = 3'd0,
        OP_BRU   = 3'd1,
        OP_LSU   = 3'd2,
        OP_MUL   = 3'd3,
        OP_DIV   = 3'd4,
        OP_CSR   = 3'd5,
        OP_TLB   = 3'd6,
        OP_OTHER = 3'd7
    } optype_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        pred_taken;
        logic [31:0] pred_target;
    } iq_entry_t;

    typedef enum logic {
        IQ_ISSUE = 1'b0,
        IQ_WAIT  = 1'b1
    } iq_state_t;

    // Ops that must drain the backend before anything younger may issue.
    function automatic logic is_serial(input optype_t op, input logic have_excp);
        return (op == OP_CSR) || (op == OP_TLB) || have_excp;
    endfunction

endpackage

// File: rtl/iq_ram.sv
// Entry storage for the issue queue: synchronous write, asynchronous read,
// cleared to zero on reset so the head shows zero data after reset.
module iq_ram
    import issue_queue_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  iq_entry_t     wdata,
    input  logic [AW-1:0] raddr,
    output iq_entry_t     rdata
);

    iq_entry_t mem [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/issue_queue.sv
// Fetch-to-decode instruction buffer with serialisation of CSR/TLB/exception ops
// and discard of younger entries on branch redirect or backend flush.
//
//  state    | meaning
//  ---------+---------------------------------------------------------------
//  IQ_ISSUE | head entry offered to decoder whenever the queue is non-empty
//  IQ_WAIT  | serialising op issued; issue blocked until serial_done pulses
module issue_queue
    import issue_queue_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_valid,
    output logic        if_ready,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_inst,
    input  logic        if_pred_taken,
    input  logic [31:0] if_pred_target,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_pred_taken,
    output logic [31:0] id_pred_target,
    input  optype_t     dec_optype,
    input  logic        dec_have_excp,
    input  logic        dec_br_mistaken,
    input  logic        flush,
    input  logic        serial_done,
    output logic        serial_wait
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL    = CW'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [AW-1:0] head, head_n, tail, tail_n;
    logic [CW-1:0] count, count_n;
    iq_state_t     state, state_n;
    iq_entry_t     wr_entry, head_entry;
    logic          enq, iss, drop, serial_op, ram_we;

    assign if_ready    = !reset && !flush && (count != FULL);
    assign id_valid    = (count != '0) && (state == IQ_ISSUE) && !flush;
    assign serial_wait = (state == IQ_WAIT);

    assign enq       = if_valid && if_ready;
    assign iss       = id_valid && id_ready;
    assign drop      = iss && dec_br_mistaken;
    assign serial_op = is_serial(dec_optype, dec_have_excp);
    // A redirect discards the same-cycle fetch, so keep it out of storage.
    assign ram_we    = enq && !drop;

    assign wr_entry = '{pc: if_pc, inst: if_inst, pred_taken: if_pred_taken,
                        pred_target: if_pred_target};

    iq_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (ram_we),
        .waddr (tail),
        .wdata (wr_entry),
        .raddr (head),
        .rdata (head_entry)
    );

    assign id_pc          = head_entry.pc;
    assign id_inst        = head_entry.inst;
    assign id_pred_taken  = head_entry.pred_taken;
    assign id_pred_target = head_entry.pred_target;

    always_comb begin
        head_n  = head;
        tail_n  = tail;
        count_n = count;
        state_n = state;
        if (flush) begin
            head_n  = tail;
            count_n = '0;
            state_n = IQ_ISSUE;
        end else if (drop) begin
            head_n  = head + PTR_ONE;
            tail_n  = head + PTR_ONE;
            count_n = '0;
            if (serial_op) state_n = IQ_WAIT;
        end else begin
            if (enq) tail_n = tail + PTR_ONE;
            if (iss) head_n = head + PTR_ONE;
            case ({enq, iss})
                2'b10:   count_n = count + CNT_ONE;
                2'b01:   count_n = count - CNT_ONE;
                default: count_n = count;
            endcase
            case (state)
                IQ_ISSUE: if (iss && serial_op) state_n = IQ_WAIT;
                IQ_WAIT:  if (serial_done) state_n = IQ_ISSUE;
                default:  state_n = IQ_ISSUE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            state <= IQ_ISSUE;
        end else begin
            head  <= head_n;
            tail  <= tail_n;
            count <= count_n;
            state <= state_n;
        end
    end

    // count is unsigned, so an underflow shows up as a value above DEPTH too.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (count <= FULL);
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue: a queue-based reference model checked every
// cycle, plus hand-computed expectations for each scenario.
module tb_issue_queue;
    import issue_queue_pkg::*;

    localparam int DEPTH = 8;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        pt;
        logic [31:0] tgt;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        if_valid = 1'b0;
    logic        if_ready;
    logic [31:0] if_pc = '0;
    logic [31:0] if_inst = '0;
    logic        if_pred_taken = 1'b0;
    logic [31:0] if_pred_target = '0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_pred_taken;
    logic [31:0] id_pred_target;
    optype_t     dec_optype = OP_ALU;
    logic        dec_have_excp = 1'b0;
    logic        dec_br_mistaken = 1'b0;
    logic        flush = 1'b0;
    logic        serial_done = 1'b0;
    logic        serial_wait;

    always #5 clk = ~clk;

    issue_queue #(.DEPTH(DEPTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .if_valid        (if_valid),
        .if_ready        (if_ready),
        .if_pc           (if_pc),
        .if_inst         (if_inst),
        .if_pred_taken   (if_pred_taken),
        .if_pred_target  (if_pred_target),
        .id_valid        (id_valid),
        .id_ready        (id_ready),
        .id_pc           (id_pc),
        .id_inst         (id_inst),
        .id_pred_taken   (id_pred_taken),
        .id_pred_target  (id_pred_target),
        .dec_optype      (dec_optype),
        .dec_have_excp   (dec_have_excp),
        .dec_br_mistaken (dec_br_mistaken),
        .flush           (flush),
        .serial_done     (serial_done),
        .serial_wait     (serial_wait)
    );

    ent_t        mq[$];
    bit          m_wait = 1'b0;
    logic [31:0] iss_pc[$];
    int          iss_cyc[$];
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit exp_if_ready();
        return !reset && !flush && (mq.size() < DEPTH);
    endfunction

    function automatic bit exp_id_valid();
        return (mq.size() > 0) && !m_wait && !flush;
    endfunction

    function automatic optype_t decode(input logic [31:0] inst);
        case (inst[31:24])
            8'h04:   return OP_CSR;
            8'h06:   return OP_TLB;
            default: return OP_ALU;
        endcase
    endfunction

    // Reference model: advances on each clock edge, cleared by reset.
    initial begin : model
        bit   enq, iss, ser;
        ent_t e;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                mq.delete();
                m_wait = 1'b0;
            end else begin
                cyc++;
                enq = exp_if_ready() && if_valid;
                iss = exp_id_valid() && id_ready;
                ser = iss && (dec_optype == OP_CSR || dec_optype == OP_TLB || dec_have_excp);
                e   = '{pc: if_pc, inst: if_inst, pt: if_pred_taken, tgt: if_pred_target};
                if (iss) begin
                    iss_pc.push_back(mq[0].pc);
                    iss_cyc.push_back(cyc);
                end
                if (flush) begin
                    mq.delete();
                    m_wait = 1'b0;
                end else if (iss && dec_br_mistaken) begin
                    mq.delete();
                    m_wait = ser;
                end else begin
                    if (iss) void'(mq.pop_front());
                    if (enq) mq.push_back(e);
                    if (m_wait) begin
                        if (serial_done) m_wait = 1'b0;
                    end else if (ser) begin
                        m_wait = 1'b1;
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin : compare
        forever begin
            @(negedge clk);
            check("if_ready", if_ready, exp_if_ready());
            check("id_valid", id_valid, exp_id_valid());
            check("serial_wait", serial_wait, m_wait);
            check("count", dut.count, mq.size());
            if (exp_id_valid()) begin
                check("id_pc", id_pc, mq[0].pc);
                check("id_inst", id_inst, mq[0].inst);
                check("id_pred_taken", id_pred_taken, mq[0].pt);
                check("id_pred_target", id_pred_target, mq[0].tgt);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
        dec_optype = (mq.size() > 0) ? decode(mq[0].inst) : OP_ALU;
    endtask

    task automatic put(input logic [31:0] pc, input logic [31:0] inst);
        if_valid       = 1'b1;
        if_pc          = pc;
        if_inst        = inst;
        if_pred_taken  = pc[2];
        if_pred_target = pc + 32'h100;
    endtask

    int base;
    int pulse_cyc;

    initial begin
        #1 reset = 1'b1;
        #2;
        check("rst_id_valid", id_valid, 0);
        check("rst_if_ready", if_ready, 0);
        check("rst_serial_wait", serial_wait, 0);
        check("rst_id_pc", id_pc, 0);
        check("rst_count", dut.count, 0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("rst_release_if_ready", if_ready, 1);

        // 1: fill to full, then drain in order at one per cycle
        base = iss_pc.size();
        for (int k = 0; k < 9; k++) begin
            put(32'h1c000000 + 32'(4 * k), 32'h00100000 + 32'(k));
            if (k == 7) check("t1_ready_before_full", if_ready, 1);
            if (k == 8) check("t1_full_if_ready", if_ready, 0);
            tick();
        end
        if_valid = 1'b0;
        check("t1_count_full", dut.count, 8);
        id_ready = 1'b1;
        repeat (8) tick();
        id_ready = 1'b0;
        check("t1_issued", iss_pc.size() - base, 8);
        for (int i = 0; i < 8; i++) begin
            check("t1_pc_order", iss_pc[base + i], 32'h1c000000 + 32'(4 * i));
            check("t1_back_to_back", iss_cyc[base + i], iss_cyc[base] + i);
        end
        check("t1_count_empty", dut.count, 0);

        // 2: concurrent enqueue/issue across pointer wrap
        base = iss_pc.size();
        id_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            put(32'h1c001000 + 32'(4 * k), 32'h00300000 + 32'(k));
            tick();
            check("t2_count_steady", dut.count, 1);
        end
        if_valid = 1'b0;
        tick();
        id_ready = 1'b0;
        check("t2_issued", iss_pc.size() - base, 20);
        for (int i = 0; i < 20; i++) begin
            check("t2_pc_order", iss_pc[base + i], 32'h1c001000 + 32'(4 * i));
            check("t2_no_gap", iss_cyc[base + i], iss_cyc[base] + i);
        end

        // 3: branch redirect drops younger entries and the same-cycle fetch
        base = iss_pc.size();
        for (int k = 0; k < 5; k++) begin
            put(32'h1c002000 + 32'(4 * k), 32'h00400000 + 32'(k));
            dec_br_mistaken = (k == 2);
            tick();
        end
        put(32'h1c002100, 32'h00400100);
        id_ready = 1'b1;
        dec_br_mistaken = 1'b1;
        tick();
        dec_br_mistaken = 1'b0;
        if_valid = 1'b0;
        #1;
        check("t3_issued_head", iss_pc[base], 32'h1c002000);
        check("t3_count_after_redirect", dut.count, 0);
        check("t3_no_valid", id_valid, 0);
        put(32'h1c003000, 32'h00500000);
        tick();
        if_valid = 1'b0;
        tick();
        id_ready = 1'b0;
        check("t3_issue_count", iss_pc.size() - base, 2);
        check("t3_next_pc", iss_pc[base + 1], 32'h1c003000);

        // 4: CSR serialisation, resume the cycle after serial_done
        base = iss_pc.size();
        put(32'h1c004000, 32'h04000400);
        tick();
        for (int k = 1; k < 4; k++) begin
            put(32'h1c004000 + 32'(4 * k), 32'h00600000 + 32'(k));
            tick();
        end
        if_valid = 1'b0;
        id_ready = 1'b1;
        tick();
        check("t4_csr_issued", iss_pc[base], 32'h1c004000);
        for (int w = 0; w < 5; w++) begin
            check("t4_serial_wait", serial_wait, 1);
            check("t4_id_valid_blocked", id_valid, 0);
            if (w < 4) tick();
        end
        serial_done = 1'b1;
        tick();
        serial_done = 1'b0;
        pulse_cyc = cyc;
        check("t4_wait_released", serial_wait, 0);
        check("t4_valid_resumed", id_valid, 1);
        tick();
        check("t4_next_pc", iss_pc[base + 1], 32'h1c004004);
        check("t4_resume_cycle", iss_cyc[base + 1], pulse_cyc + 1);
        repeat (2) tick();
        id_ready = 1'b0;
        check("t4_total", iss_pc.size() - base, 4);

        // 5: flush beats enqueue and issue while waiting
        base = iss_pc.size();
        for (int k = 0; k < 5; k++) begin
            put(32'h1c005000 + 32'(4 * k), 32'h00700000 + 32'(k));
            tick();
        end
        if_valid = 1'b0;
        id_ready = 1'b1;
        dec_have_excp = 1'b1;
        tick();
        dec_have_excp = 1'b0;
        check("t5_count_4", dut.count, 4);
        check("t5_in_wait", serial_wait, 1);
        flush = 1'b1;
        put(32'h1c005100, 32'h00700100);
        #1;
        check("t5_flush_if_ready", if_ready, 0);
        check("t5_flush_id_valid", id_valid, 0);
        tick();
        flush = 1'b0;
        if_valid = 1'b0;
        #1;
        check("t5_count_0", dut.count, 0);
        check("t5_state_issue", serial_wait, 0);
        check("t5_if_ready", if_ready, 1);
        check("t5_one_issue", iss_pc.size() - base, 1);
        id_ready = 1'b0;

        // 6: async reset mid-fill while waiting on a TLB op
        put(32'h1c006000, 32'h06000000);
        tick();
        for (int k = 1; k < 6; k++) begin
            put(32'h1c006000 + 32'(4 * k), 32'h00800000 + 32'(k));
            tick();
        end
        if_valid = 1'b0;
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
        check("t6_count_5", dut.count, 5);
        check("t6_wait", serial_wait, 1);
        #1 reset = 1'b1;
        #1;
        check("t6_rst_id_valid", id_valid, 0);
        check("t6_rst_serial_wait", serial_wait, 0);
        check("t6_rst_if_ready", if_ready, 0);
        check("t6_rst_id_pc", id_pc, 0);
        tick();
        #1 reset = 1'b0;
        #1;
        check("t6_post_count", dut.count, 0);
        check("t6_post_if_ready", if_ready, 1);
        check("t6_post_id_valid", id_valid, 0);
        base = iss_pc.size();
        put(32'h1c007000, 32'h00900000);
        id_ready = 1'b1;
        tick();
        if_valid = 1'b0;
        tick();
        id_ready = 1'b0;
        check("t6_post_issue", iss_pc[base], 32'h1c007000);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
